// File: rtl/usb_tx_arbiter.sv
// Two-requester byte arbiter for a USB serial peripheral. For each granted byte it
// polls STATUS until the TX FIFO has space, then writes DATA on a select/ready bus.
module usb_tx_arbiter #(
    parameter logic [31:0] BASE_ADDR    = 32'h0002_0000,
    parameter int unsigned LOCK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  req0_data,
    input  logic [7:0]  req1_data,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic        req0_last,
    input  logic        req1_last,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic [31:0] address_out,
    output logic        sel_out,
    output logic        read_out,
    output logic [3:0]  write_mask_out,
    output logic [31:0] write_value_out,
    input  logic [31:0] read_value_in,
    input  logic        ready_in,
    output logic        grant,
    output logic        locked,
    output logic [15:0] poll_retries
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_POLL_REQ = 2'd1;
    localparam logic [1:0] S_POLL_CHK = 2'd2;
    localparam logic [1:0] S_WRITE    = 2'd3;

    localparam logic [31:0] ADDR_STATUS  = BASE_ADDR + 32'd4;
    localparam logic [31:0] ADDR_DATA    = BASE_ADDR + 32'd8;
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_grant;
    logic        r_locked;
    logic        r_rr_next;
    logic [7:0]  r_data;
    logic        r_last;
    logic [15:0] r_lock_cnt;
    logic [15:0] r_poll_retries;
    logic        r_sel;
    logic        r_read;
    logic [3:0]  r_mask;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [1:0]  w_state_nxt;
    logic        w_win;
    logic        w_win_valid;
    logic [7:0]  w_win_data;
    logic        w_win_last;
    logic        w_write_done;
    logic        w_unused;

    // Arbitration: a held lock pins the owner, otherwise round-robin between valid requesters
    always_comb begin
        w_win       = r_rr_next;
        w_win_valid = 1'b0;
        if (r_locked) begin
            w_win       = r_grant;
            w_win_valid = r_grant ? req1_valid : req0_valid;
        end else if (req0_valid && req1_valid) begin
            w_win_valid = 1'b1;
        end else if (req0_valid) begin
            w_win       = 1'b0;
            w_win_valid = 1'b1;
        end else if (req1_valid) begin
            w_win       = 1'b1;
            w_win_valid = 1'b1;
        end else begin
            w_win_valid = 1'b0;
        end
    end

    assign w_win_data   = w_win ? req1_data : req0_data;
    assign w_win_last   = w_win ? req1_last : req0_last;
    assign w_write_done = (r_state == S_WRITE) && ready_in;
    assign w_unused     = ^read_value_in[31:1];

    // Next-state decode of the bus sequencer
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:     w_state_nxt = w_win_valid ? S_POLL_REQ : S_IDLE;
            S_POLL_REQ: w_state_nxt = ready_in ? S_POLL_CHK : S_POLL_REQ;
            S_POLL_CHK: w_state_nxt = read_value_in[0] ? S_WRITE : S_POLL_REQ;
            S_WRITE:    w_state_nxt = ready_in ? S_IDLE : S_WRITE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state, grant/lock ownership, latched byte and lock idle timer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_grant    <= 1'b0;
            r_locked   <= 1'b0;
            r_rr_next  <= 1'b0;
            r_data     <= 8'h00;
            r_last     <= 1'b0;
            r_lock_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE) begin
                if (w_win_valid) begin
                    r_grant    <= w_win;
                    r_locked   <= 1'b1;
                    r_data     <= w_win_data;
                    r_last     <= w_win_last;
                    r_lock_cnt <= 16'd0;
                end else if (r_locked) begin
                    // Owner went quiet mid-packet: release after the idle budget, pointer untouched
                    if (r_lock_cnt >= TIMEOUT_LAST) begin
                        r_locked   <= 1'b0;
                        r_lock_cnt <= 16'd0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + 16'd1;
                    end
                end else begin
                    r_lock_cnt <= 16'd0;
                end
            end else if (w_write_done && r_last) begin
                r_locked  <= 1'b0;
                r_rr_next <= ~r_grant;
            end
        end
    end

    // Saturating count of STATUS polls that found the FIFO full
    always_ff @(posedge clk) begin
        if (reset) begin
            r_poll_retries <= 16'd0;
        end else if ((r_state == S_POLL_CHK) && !read_value_in[0] && (r_poll_retries != 16'hFFFF)) begin
            r_poll_retries <= r_poll_retries + 16'd1;
        end
    end

    // Bus outputs registered from the next state so they line up with the state they describe
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel   <= 1'b0;
            r_read  <= 1'b0;
            r_mask  <= 4'b0000;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            case (w_state_nxt)
                S_POLL_REQ: begin
                    r_sel   <= 1'b1;
                    r_read  <= 1'b1;
                    r_mask  <= 4'b0000;
                    r_addr  <= ADDR_STATUS;
                    r_wdata <= 32'd0;
                end
                S_WRITE: begin
                    r_sel   <= 1'b1;
                    r_read  <= 1'b0;
                    r_mask  <= 4'b0001;
                    r_addr  <= ADDR_DATA;
                    r_wdata <= {24'd0, r_data};
                end
                default: begin
                    r_sel   <= 1'b0;
                    r_read  <= 1'b0;
                    r_mask  <= 4'b0000;
                    r_addr  <= 32'd0;
                    r_wdata <= 32'd0;
                end
            endcase
        end
    end

    // The acknowledge must land in the same cycle the slave takes the write, so it stays combinational
    assign req0_ready = w_write_done && !r_grant && !reset;
    assign req1_ready = w_write_done && r_grant && !reset;

    assign address_out     = r_addr;
    assign sel_out         = r_sel;
    assign read_out        = r_read;
    assign write_mask_out  = r_mask;
    assign write_value_out = r_wdata;
    assign grant           = r_grant;
    assign locked          = r_locked;
    assign poll_retries    = r_poll_retries;

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Self-checking bench for usb_tx_arbiter: vector table, directed corner sequences,
// and randomized packets against a packet-level round-robin reference.
module tb_usb_tx_arbiter;
    localparam logic [31:0] BASE = 32'h0002_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  req0_data, req1_data;
    logic        req0_valid, req1_valid, req0_last, req1_last;
    logic        req0_ready, req1_ready;
    logic [31:0] address_out, write_value_out, read_value_in;
    logic        sel_out, read_out, ready_in, grant, locked;
    logic [3:0]  write_mask_out;
    logic [15:0] poll_retries;

    usb_tx_arbiter #(.BASE_ADDR(BASE), .LOCK_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .req0_data(req0_data), .req1_data(req1_data),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_last(req0_last), .req1_last(req1_last),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .address_out(address_out), .sel_out(sel_out), .read_out(read_out),
        .write_mask_out(write_mask_out), .write_value_out(write_value_out),
        .read_value_in(read_value_in), .ready_in(ready_in),
        .grant(grant), .locked(locked), .poll_retries(poll_retries)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] val;
        logic [3:0]  mask;
        int          src;
        int          cyc;
    } wr_t;

    typedef struct {
        int         req;
        logic [7:0] data;
        logic       last;
        int         full;
        int         stall;
        logic       exp_locked;
    } vec_t;

    typedef struct {
        int         src;
        logic [7:0] data;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    // requester byte stores: main pushes (wrN), driver consumes (rdN)
    logic [7:0] q0d [0:511];
    logic       q0l [0:511];
    logic [7:0] q1d [0:511];
    logic       q1l [0:511];
    int wr0 = 0, wr1 = 0;
    int rd0, rd1, pres0, pres1, pidx0, pidx1;

    // slave controls (main) and slave-owned counters
    int   zeros_target = 0, wr_stall_target = 0;
    logic rand_full = 1'b0, rand_stall = 1'b0, stall_hold = 1'b0, scramble = 1'b0;
    int   zeros_given, wr_stall_given;

    // monitor-owned logs
    wr_t  wlog[$];
    int   rlog[$];
    int   bad_rd, stray, unstable;

    always @(posedge clk) cyc = cyc + 1;

    // requester driver: present head bytes, pop on the ready pulse
    initial begin
        logic a0, a1;
        rd0 = 0; rd1 = 0; pres0 = 0; pres1 = 0; pidx0 = -1; pidx1 = -1;
        req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
        req0_last = 1'b0; req1_last = 1'b0;
        forever begin
            @(negedge clk);
            a0 = req0_ready; a1 = req1_ready;
            @(posedge clk); #1;
            if (a0) rd0++;
            if (a1) rd1++;
            if (scramble && sel_out) begin
                req0_data = 8'($urandom); req1_data = 8'($urandom);
                req0_last = 1'($urandom); req1_last = 1'($urandom);
                req0_valid = 1'($urandom); req1_valid = 1'($urandom);
            end else begin
                req0_valid = (rd0 < wr0);
                req1_valid = (rd1 < wr1);
                req0_data  = (rd0 < wr0) ? q0d[rd0] : 8'h00;
                req0_last  = (rd0 < wr0) ? q0l[rd0] : 1'b0;
                req1_data  = (rd1 < wr1) ? q1d[rd1] : 8'h00;
                req1_last  = (rd1 < wr1) ? q1l[rd1] : 1'b0;
                if (rd0 < wr0 && pidx0 != rd0) begin pres0 = cyc; pidx0 = rd0; end
                if (rd1 < wr1 && pidx1 != rd1) begin pres1 = cyc; pidx1 = rd1; end
            end
        end
    end

    // bus slave: STATUS replies and write-side stalls
    initial begin
        logic acc_rd;
        zeros_given = 0; wr_stall_given = 0;
        ready_in = 1'b1; read_value_in = 32'd0;
        forever begin
            @(negedge clk);
            acc_rd = sel_out && read_out && ready_in;
            @(posedge clk); #1;
            if (acc_rd) begin
                if (zeros_given < zeros_target || (rand_full && $urandom_range(0, 3) == 0)) begin
                    read_value_in = $urandom & 32'hFFFF_FFFE;
                    zeros_given++;
                end else begin
                    read_value_in = $urandom | 32'h0000_0001;
                end
            end else begin
                read_value_in = 32'd0;
            end
            if (sel_out && !read_out) begin
                if (stall_hold) ready_in = 1'b0;
                else if (wr_stall_given < wr_stall_target) begin ready_in = 1'b0; wr_stall_given++; end
                else if (rand_stall && $urandom_range(0, 3) == 0) ready_in = 1'b0;
                else ready_in = 1'b1;
            end else if (sel_out && rand_stall) begin
                ready_in = ($urandom_range(0, 3) != 0);
            end else begin
                ready_in = 1'b1;
            end
        end
    end

    // bus monitor: log accepted reads/writes, stray acks, stall stability
    initial begin
        wr_t e;
        logic prev_wait;
        logic [67:0] prev_bus;
        bad_rd = 0; stray = 0; unstable = 0; prev_wait = 1'b0; prev_bus = '0;
        forever begin
            @(negedge clk);
            if (sel_out && read_out && ready_in) begin
                rlog.push_back(cyc);
                if (address_out !== BASE + 32'd4 || write_mask_out !== 4'd0) bad_rd++;
            end
            if (sel_out && !read_out && ready_in) begin
                e.addr = address_out; e.val = write_value_out; e.mask = write_mask_out; e.cyc = cyc;
                e.src = (req0_ready && !req1_ready) ? 0 : ((req1_ready && !req0_ready) ? 1 : 2);
                wlog.push_back(e);
            end else if (req0_ready || req1_ready) begin
                stray++;
            end
            if (prev_wait && sel_out && !read_out && ({address_out, write_value_out, write_mask_out} !== prev_bus))
                unstable++;
            prev_wait = sel_out && !read_out && !ready_in;
            prev_bus  = {address_out, write_value_out, write_mask_out};
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(negedge clk); #1;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        if (r == 0) begin q0d[wr0] = d; q0l[wr0] = l; wr0++; end
        else        begin q1d[wr1] = d; q1l[wr1] = l; wr1++; end
    endtask

    task automatic wait_wr(input int n, input int lim, input string nm);
        int c = 0;
        while (wlog.size() < n && c < lim) begin step; c++; end
        chk(nm, 32'(wlog.size() >= n), 32'd1);
    endtask

    function automatic wr_t get_wr(input int i);
        wr_t e;
        e = '{32'hX, 32'hX, 4'hX, -1, -1};
        if (i < wlog.size()) e = wlog[i];
        return e;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) step;
        reset = 1'b0;
        zeros_target = zeros_given;
        wr_stall_target = wr_stall_given;
    endtask

    initial begin
        vec_t vt[6];
        wr_t  e;
        int   nw, nr, exp_ret, w, p, g0;
        exp_t expq[$];
        logic [7:0] pdat[2][$];
        int   plen[2][6];

        vt[0] = '{0, 8'h41, 1'b1, 0, 0,  1'b0};
        vt[1] = '{1, 8'h5A, 1'b0, 0, 2,  1'b1};
        vt[2] = '{1, 8'hA5, 1'b1, 3, 0,  1'b0};
        vt[3] = '{0, 8'h00, 1'b0, 1, 10, 1'b1};
        vt[4] = '{0, 8'hFF, 1'b1, 0, 0,  1'b0};
        vt[5] = '{1, 8'h7E, 1'b1, 2, 1,  1'b0};

        // reset state, sampled while reset is held
        reset = 1'b1;
        repeat (3) step;
        chk("rst_sel", 32'(sel_out), 32'd0);
        chk("rst_read", 32'(read_out), 32'd0);
        chk("rst_mask", 32'(write_mask_out), 32'd0);
        chk("rst_addr", address_out, 32'd0);
        chk("rst_wval", write_value_out, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_retries", 32'(poll_retries), 32'd0);
        chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        reset = 1'b0;
        step;

        // vector table: one byte each, latency = 3 + 2*full polls + write stalls
        exp_ret = 0;
        for (int i = 0; i < 6; i++) begin
            zeros_target    = zeros_given + vt[i].full;
            wr_stall_target = wr_stall_given + vt[i].stall;
            nw = wlog.size(); nr = rlog.size();
            push(vt[i].req, vt[i].data, vt[i].last);
            wait_wr(nw + 1, 200, $sformatf("v%0d_done", i));
            e = get_wr(nw);
            p = (vt[i].req == 0) ? pres0 : pres1;
            exp_ret += vt[i].full;
            chk($sformatf("v%0d_wval", i), e.val, {24'd0, vt[i].data});
            chk($sformatf("v%0d_waddr", i), e.addr, BASE + 32'd8);
            chk($sformatf("v%0d_mask", i), 32'(e.mask), 32'd1);
            chk($sformatf("v%0d_src", i), 32'(e.src), 32'(vt[i].req));
            chk($sformatf("v%0d_lat", i), 32'(e.cyc - p), 32'(3 + 2 * vt[i].full + vt[i].stall));
            chk($sformatf("v%0d_poll1", i), 32'((rlog.size() > nr) ? rlog[nr] - p : -1), 32'd1);
            chk($sformatf("v%0d_npoll", i), 32'(rlog.size() - nr), 32'(vt[i].full + 1));
            step;
            chk($sformatf("v%0d_locked", i), 32'(locked), 32'(vt[i].exp_locked));
            chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].req));
            chk($sformatf("v%0d_retries", i), 32'(poll_retries), 32'(exp_ret));
            chk($sformatf("v%0d_sel_idle", i), 32'(sel_out), 32'd0);
        end

        // contention: two 2-byte packets, no interleaving
        do_reset;
        nw = wlog.size();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
        wait_wr(nw + 4, 200, "cont_done");
        for (int i = 0; i < 4; i++) begin
            e = get_wr(nw + i);
            chk($sformatf("cont%0d_src", i), 32'(e.src), 32'(i / 2));
            chk($sformatf("cont%0d_val", i), e.val, 32'(8'h10 + 8'h10 * (i / 2) + i % 2));
        end

        // lock timeout: owner drops valid mid-packet, other requester waits 4 idle cycles
        do_reset;
        nw = wlog.size();
        push(0, 8'h30, 1'b0);
        push(1, 8'h40, 1'b1);
        wait_wr(nw + 1, 100, "to_first");
        e = get_wr(nw);
        w = e.cyc;
        chk("to_first_src", 32'(e.src), 32'd0);
        repeat (4) step;
        chk("to_locked_w4", 32'(locked), 32'd1);
        chk("to_grant_w4", 32'(grant), 32'd0);
        step;
        chk("to_locked_w5", 32'(locked), 32'd0);
        chk("to_grant_w5", 32'(grant), 32'd0);
        step;
        chk("to_grant_w6", 32'(grant), 32'd1);
        chk("to_locked_w6", 32'(locked), 32'd1);
        wait_wr(nw + 2, 100, "to_second");
        e = get_wr(nw + 1);
        chk("to_second_src", 32'(e.src), 32'd1);
        chk("to_second_val", e.val, 32'h40);
        chk("to_second_cyc", 32'(e.cyc - w), 32'd8);

        // reset in the middle of a stalled write: no ack, byte re-offered and written once
        do_reset;
        zeros_target = zeros_given + 2;
        stall_hold = 1'b1;
        nw = wlog.size();
        push(0, 8'h55, 1'b1);
        begin
            int c = 0;
            while (!(sel_out && !read_out) && c < 100) begin step; c++; end
        end
        chk("mid_in_write", 32'(sel_out && !read_out), 32'd1);
        repeat (3) step;
        chk("mid_retries", 32'(poll_retries), 32'd2);
        reset = 1'b1;
        step;
        chk("mid_rst_sel", 32'(sel_out), 32'd0);
        chk("mid_rst_retries", 32'(poll_retries), 32'd0);
        chk("mid_rst_locked", 32'(locked), 32'd0);
        chk("mid_rst_nowrite", 32'(wlog.size()), 32'(nw));
        reset = 1'b0;
        stall_hold = 1'b0;
        zeros_target = zeros_given;
        wr_stall_target = wr_stall_given;
        wait_wr(nw + 1, 100, "mid_reoffer");
        e = get_wr(nw);
        chk("mid_reoffer_val", e.val, 32'h55);
        chk("mid_reoffer_src", 32'(e.src), 32'd0);
        repeat (10) step;
        chk("mid_once", 32'(wlog.size()), 32'(nw + 1));

        // randomized packets with FIFO-full polls, bus stalls and input scrambling while busy
        do_reset;
        g0 = zeros_given;
        nw = wlog.size();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 6; k++) begin
                plen[r][k] = $urandom_range(1, 3);
                for (int b = 0; b < plen[r][k]; b++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    pdat[r].push_back(d);
                    push(r, d, b == plen[r][k] - 1);
                end
            end
        end
        rand_full = 1'b1; rand_stall = 1'b1; scramble = 1'b1;
        begin
            int pi[2], bi[2], turn, r;
            pi = '{0, 0}; bi = '{0, 0}; turn = 0;
            while (pi[0] < 6 || pi[1] < 6) begin
                r = (pi[turn] < 6) ? turn : 1 - turn;
                for (int b = 0; b < plen[r][pi[r]]; b++) begin
                    expq.push_back('{r, pdat[r][bi[r]]});
                    bi[r]++;
                end
                pi[r]++;
                turn = 1 - r;
            end
        end
        wait_wr(nw + expq.size(), 4000, "rnd_done");
        rand_full = 1'b0; rand_stall = 1'b0; scramble = 1'b0;
        repeat (5) step;
        for (int i = 0; i < expq.size(); i++) begin
            e = get_wr(nw + i);
            chk($sformatf("rnd%0d_src", i), 32'(e.src), 32'(expq[i].src));
            chk($sformatf("rnd%0d_val", i), e.val, {24'd0, expq[i].data});
        end
        chk("rnd_count", 32'(wlog.size() - nw), 32'(expq.size()));
        chk("rnd_retries", 32'(poll_retries), 32'(zeros_given - g0));
        chk("rnd_locked_end", 32'(locked), 32'd0);

        chk("bad_read_addr", 32'(bad_rd), 32'd0);
        chk("stray_ready", 32'(stray), 32'd0);
        chk("stall_stable", 32'(unstable), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/usb_tx_arbiter.md
USB_TX_ARBITER -- requirements
Module: usb_tx_arbiter

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0002_0000, byte base address of the USB serial peripheral register window.
REQ-002 Parameter: LOCK_TIMEOUT, 255, idle cycles after which a held packet lock is released; range 1..65535.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: req0_data / req1_data  in  8  byte offered by requester 0 / 1.
REQ-006 Port: req0_valid / req1_valid  in  1  requester has a byte pending.
REQ-007 Port: req0_last / req1_last  in  1  pending byte ends a packet.
REQ-008 Port: req0_ready / req1_ready  out  1  one-cycle pulse; the byte was written to the peripheral.
REQ-009 Port: address_out  out  32  bus address.
REQ-010 Port: sel_out  out  1  bus select.
REQ-011 Port: read_out  out  1  bus read strobe.
REQ-012 Port: write_mask_out  out  4  byte-lane write enables.
REQ-013 Port: write_value_out  out  32  write data.
REQ-014 Port: read_value_in  in  32  read data; valid the cycle after the accepted read.
REQ-015 Port: ready_in  in  1  slave accepts the current sel_out cycle.
REQ-016 Port: grant  out  1  requester currently owning the channel (0/1).
REQ-017 Port: locked  out  1  packet lock held by grant.
REQ-018 Port: poll_retries  out  16  saturating count of STATUS polls that reported no FIFO space.

Function
REQ-019 FSM states: IDLE, POLL_REQ, POLL_CHK, WRITE.
REQ-020 IDLE: sel_out=0. If locked, only requester grant is eligible. Otherwise, with both valid, the requester other than the last packet's owner wins (round-robin); with one valid, that one wins. The winner's data/last are latched, grant updated, locked set; go to POLL_REQ.
REQ-021 POLL_REQ: sel_out=1, read_out=1, write_mask_out=0, address_out=BASE_ADDR+4. Stay until ready_in=1, then go to POLL_CHK.
REQ-022 POLL_CHK: sel_out=0; sample read_value_in[0]. If 1, go to WRITE. If 0, go to POLL_REQ and increment poll_retries, saturating at 16'hFFFF.
REQ-023 WRITE: sel_out=1, read_out=0, write_mask_out=4'b0001, address_out=BASE_ADDR+8, write_value_out={24'b0, latched byte}. Stay until ready_in=1.
REQ-024 In the cycle WRITE sees ready_in=1, req<grant>_ready=1 (combinational on state, grant, ready_in), then go to IDLE.
REQ-025 Only the granted requester's ready is ever asserted; at most one ready per written byte.
REQ-026 If the written byte had last=1: locked clears and the round-robin pointer moves to the other requester.
REQ-027 Requester data/valid/last changes after latching are ignored until its ready pulse; a byte is never lost or duplicated.
REQ-028 Minimum latency with ready_in tied high and space available: valid in IDLE at cycle N; poll at N+1; check at N+2; write and ready pulse at N+3; back in IDLE at N+4.
REQ-029 Lock timeout counter counts consecutive IDLE cycles with locked=1 and the granted requester's valid=0. It reaches LOCK_TIMEOUT, then clears locked with the pointer unchanged; the counter zeroes on any grant.
REQ-030 Outside POLL_REQ and WRITE: sel_out=0, read_out=0, write_mask_out=0.
REQ-031 address_out and write_value_out are don't-care when sel_out=0, but shall be driven to 0.

Reset
REQ-032 Reset in any state: next state IDLE, sel_out/read_out/ready=0, write_mask_out=0, address_out/write_value_out=0, grant=0 with requester 0 preferred, locked=0, poll_retries=0, timeout counter=0.
REQ-033 A byte in flight when reset asserts is not acknowledged; the requester must re-offer it.

Verification
REQ-034 Single byte: req0 offers 8'h41 with last=1, ready_in=1, status bit0=1 -> read at BASE+4 at N+1; write 32'h41, mask 4'b0001 at BASE+8 at N+3; req0_ready pulses once; locked=0 after.
REQ-035 Contention: both requesters valid, each with 2-byte packets -> order is r0,r0(last),r1,r1(last); no interleaving.
REQ-036 Full FIFO: status bit0=0 for 3 polls, then 1 -> three POLL_REQ/POLL_CHK loops, poll_retries=3, then a single write.
REQ-037 Lock timeout, LOCK_TIMEOUT=4: req0 sends a non-last byte and then drops valid while req1 is valid -> req1 is granted on the 5th idle cycle.
REQ-038 Bus stall and reset: ready_in=0 for 10 cycles in WRITE holds all outputs stable. Reset asserted mid-WRITE -> next cycle sel_out=0, no ready pulse, poll_retries=0.
